// File: rtl/ccff_bitstream_shifter.sv
// Shifts plaintext bitstream words MSB-first into the fabric configuration chain,
// drives pReset/config_enable/prog_clk enable and checks the chain tail afterwards.
module ccff_bitstream_shifter #(
    parameter int WORD_W     = 32,
    parameter int CHAIN_LEN  = 4096,
    parameter int CNT_W      = 16,
    parameter int PRESET_CYC = 4
) (
    input  logic              tck_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [WORD_W-1:0] word_i,
    input  logic              word_valid_i,
    output logic              word_ready_o,
    output logic              pReset_o,
    output logic              config_enable_o,
    output logic              prog_clk_en_o,
    output logic              ccff_head_o,
    input  logic              ccff_tail_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              error_o
);

    localparam int REM_W = $clog2(WORD_W + 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] PRESET = 3'd1;
    localparam logic [2:0] SHIFT  = 3'd2;
    localparam logic [2:0] CHECK  = 3'd3;
    localparam logic [2:0] DONE   = 3'd4;

    localparam logic [CNT_W-1:0] CNT_ZERO_C   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE_C    = CNT_W'(1);
    localparam logic [CNT_W-1:0] LEN_C        = CNT_W'(CHAIN_LEN);
    localparam logic [CNT_W-1:0] LEN_M1_C     = CNT_W'(CHAIN_LEN - 1);
    localparam logic [CNT_W-1:0] PRE_LAST_C   = CNT_W'(PRESET_CYC - 1);
    localparam logic [REM_W-1:0] REM_ZERO_C   = {REM_W{1'b0}};
    localparam logic [REM_W-1:0] REM_ONE_C    = REM_W'(1);
    localparam logic [REM_W-1:0] REM_FULL_C   = REM_W'(WORD_W);
    localparam logic [REM_W-1:0] REM_BYPASS_C = REM_W'(WORD_W - 1);

    logic [2:0]        state_r,     state_s;
    logic [CNT_W-1:0]  pre_cnt_r,   pre_cnt_s;
    logic [CNT_W-1:0]  bit_cnt_r,   bit_cnt_s;
    logic [WORD_W-1:0] buf_r,       buf_s;
    logic [REM_W-1:0]  rem_r,       rem_s;
    logic              first_bit_r, first_bit_s;
    logic              ready_r,     ready_s;
    logic              preset_r,    preset_s;
    logic              cfg_en_r,    cfg_en_s;
    logic              pclk_r,      pclk_s;
    logic              head_r,      head_s;
    logic              busy_r,      busy_s;
    logic              done_r,      done_s;
    logic              error_r,     error_s;
    logic              take_s;
    logic              emit_bit_s;
    logic              discard_s;

    // Next-state and next-output computation for the whole load sequence
    always_comb begin
        state_s     = state_r;
        pre_cnt_s   = pre_cnt_r;
        bit_cnt_s   = bit_cnt_r;
        buf_s       = buf_r;
        rem_s       = rem_r;
        first_bit_s = first_bit_r;
        preset_s    = preset_r;
        cfg_en_s    = cfg_en_r;
        pclk_s      = 1'b0;
        head_s      = head_r;
        busy_s      = busy_r;
        done_s      = done_r;
        error_s     = error_r;
        emit_bit_s  = 1'b0;
        take_s      = word_valid_i & ready_r;
        // the bit emitted on this edge is the last one the chain needs
        discard_s   = (bit_cnt_r == LEN_M1_C);

        case (state_r)
            IDLE, DONE: begin
                if (start_i) begin
                    state_s   = PRESET;
                    pre_cnt_s = CNT_ZERO_C;
                    bit_cnt_s = CNT_ZERO_C;
                    rem_s     = REM_ZERO_C;
                    preset_s  = 1'b1;
                    cfg_en_s  = 1'b1;
                    busy_s    = 1'b1;
                    done_s    = 1'b0;
                    error_s   = 1'b0;
                end else begin
                    state_s = state_r;
                end
            end
            PRESET: begin
                if (pre_cnt_r == PRE_LAST_C) begin
                    state_s  = SHIFT;
                    preset_s = 1'b0;
                end else begin
                    pre_cnt_s = pre_cnt_r + CNT_ONE_C;
                end
            end
            SHIFT: begin
                if (bit_cnt_r == LEN_C) begin
                    state_s = CHECK;
                end else if ((rem_r != REM_ZERO_C) || take_s) begin
                    if (rem_r != REM_ZERO_C) begin
                        emit_bit_s = buf_r[WORD_W-1];
                        if (take_s) begin
                            buf_s = word_i;
                            rem_s = discard_s ? REM_ZERO_C : REM_FULL_C;
                        end else begin
                            buf_s = buf_r << 1;
                            rem_s = discard_s ? REM_ZERO_C : (rem_r - REM_ONE_C);
                        end
                    end else begin
                        // empty buffer: the incoming MSB goes straight to the chain
                        emit_bit_s = word_i[WORD_W-1];
                        buf_s      = word_i << 1;
                        rem_s      = discard_s ? REM_ZERO_C : REM_BYPASS_C;
                    end
                    pclk_s    = 1'b1;
                    head_s    = emit_bit_s;
                    bit_cnt_s = bit_cnt_r + CNT_ONE_C;
                    if (bit_cnt_r == CNT_ZERO_C) begin
                        first_bit_s = emit_bit_s;
                    end else begin
                        first_bit_s = first_bit_r;
                    end
                end else begin
                    head_s = head_r;
                end
            end
            CHECK: begin
                state_s  = DONE;
                error_s  = ccff_tail_i ^ first_bit_r;
                done_s   = 1'b1;
                busy_s   = 1'b0;
                cfg_en_s = 1'b0;
                head_s   = 1'b0;
            end
            default: begin
                state_s  = IDLE;
                rem_s    = REM_ZERO_C;
                preset_s = 1'b0;
                cfg_en_s = 1'b0;
                head_s   = 1'b0;
                busy_s   = 1'b0;
                done_s   = 1'b0;
                error_s  = 1'b0;
            end
        endcase

        // ready is offered only when another word is still needed by the chain
        ready_s = (state_s == SHIFT) &&
                  (((rem_s == REM_ZERO_C) && (bit_cnt_s < LEN_C)) ||
                   ((rem_s == REM_ONE_C)  && (bit_cnt_s < LEN_M1_C)));
    end

    // State and registered-output update with asynchronous reset
    always_ff @(posedge tck_i or posedge rst_i) begin
        if (rst_i) begin
            state_r     <= IDLE;
            pre_cnt_r   <= CNT_ZERO_C;
            bit_cnt_r   <= CNT_ZERO_C;
            buf_r       <= {WORD_W{1'b0}};
            rem_r       <= REM_ZERO_C;
            first_bit_r <= 1'b0;
            ready_r     <= 1'b0;
            preset_r    <= 1'b0;
            cfg_en_r    <= 1'b0;
            pclk_r      <= 1'b0;
            head_r      <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            error_r     <= 1'b0;
        end else begin
            state_r     <= state_s;
            pre_cnt_r   <= pre_cnt_s;
            bit_cnt_r   <= bit_cnt_s;
            buf_r       <= buf_s;
            rem_r       <= rem_s;
            first_bit_r <= first_bit_s;
            ready_r     <= ready_s;
            preset_r    <= preset_s;
            cfg_en_r    <= cfg_en_s;
            pclk_r      <= pclk_s;
            head_r      <= head_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
            error_r     <= error_s;
        end
    end

    assign word_ready_o    = ready_r;
    assign pReset_o        = preset_r;
    assign config_enable_o = cfg_en_r;
    assign prog_clk_en_o   = pclk_r;
    assign ccff_head_o     = head_r;
    assign busy_o          = busy_r;
    assign done_o          = done_r;
    assign error_o         = error_r;

endmodule

// File: tb/tb_ccff_bitstream_shifter.sv
// Scoreboard bench: two shifter instances (64-bit and 40-bit chains) each feeding a
// behavioural chain model; expected load results are queued and checked on done.
module tb_ccff_bitstream_shifter;

    logic        clk;
    logic        rst   [2];
    logic        start [2];
    logic [31:0] word  [2];
    logic        valid [2];
    logic        ready [2];
    logic        prst  [2];
    logic        cfg   [2];
    logic        pclk  [2];
    logic        head  [2];
    logic        tail  [2];
    logic        busy  [2];
    logic        done  [2];
    logic        err   [2];
    logic [63:0] chain [2];
    logic        stuck;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          idx;
        logic        err;
        logic [63:0] chain;
        int          pulses;
        int          gaps;
    } exp_t;
    exp_t q[$];

    int pulses [2];
    int gaps   [2];
    int pend   [2];
    int pre    [2];
    bit pr_prev[2];
    bit dn_prev[2];
    int lens   [2] = '{64, 40};

    ccff_bitstream_shifter #(.WORD_W(32), .CHAIN_LEN(64), .CNT_W(16), .PRESET_CYC(4)) dut64 (
        .tck_i(clk), .rst_i(rst[0]), .start_i(start[0]), .word_i(word[0]),
        .word_valid_i(valid[0]), .word_ready_o(ready[0]), .pReset_o(prst[0]),
        .config_enable_o(cfg[0]), .prog_clk_en_o(pclk[0]), .ccff_head_o(head[0]),
        .ccff_tail_i(tail[0]), .busy_o(busy[0]), .done_o(done[0]), .error_o(err[0]));

    ccff_bitstream_shifter #(.WORD_W(32), .CHAIN_LEN(40), .CNT_W(16), .PRESET_CYC(4)) dut40 (
        .tck_i(clk), .rst_i(rst[1]), .start_i(start[1]), .word_i(word[1]),
        .word_valid_i(valid[1]), .word_ready_o(ready[1]), .pReset_o(prst[1]),
        .config_enable_o(cfg[1]), .prog_clk_en_o(pclk[1]), .ccff_head_o(head[1]),
        .ccff_tail_i(tail[1]), .busy_o(busy[1]), .done_o(done[1]), .error_o(err[1]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Chain model: one shift per prog_clk enable, new bit enters at the head end
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (pclk[i]) chain[i] <= {chain[i][62:0], head[i]};
        end
    end
    assign tail[0] = stuck ? 1'b0 : chain[0][63];
    assign tail[1] = chain[1][39];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic push_exp(input int i, input logic e, input logic [63:0] c,
                            input int p, input int g);
        exp_t x;
        x.idx = i; x.err = e; x.chain = c; x.pulses = p; x.gaps = g;
        q.push_back(x);
    endtask

    // Monitor: per-load pulse/stall/pReset accounting and scoreboard pop on done
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (prst[i] && !pr_prev[i]) begin
                pulses[i] = 0; gaps[i] = 0; pend[i] = 0; pre[i] = 0;
            end
            if (prst[i]) pre[i]++;
            if (pclk[i]) begin
                if (pulses[i] > 0) gaps[i] += pend[i];
                pend[i] = 0;
                pulses[i]++;
                if (pulses[i] == lens[i]) chk("ready_at_last_bit", 64'(ready[i]), 64'd0);
            end else if (pulses[i] > 0) begin
                pend[i]++;
            end
            if (done[i] && !dn_prev[i]) begin
                if (q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done: instance %0d finished with no queued load", i);
                end else begin
                    exp_t e;
                    logic [63:0] c;
                    e = q.pop_front();
                    c = (i == 0) ? chain[0] : {24'h0, chain[1][39:0]};
                    chk("sb_instance", 64'(i), 64'(e.idx));
                    chk("error_o", 64'(err[i]), 64'(e.err));
                    chk("chain_content", c, e.chain);
                    chk("pulse_count", 64'(pulses[i]), 64'(e.pulses));
                    chk("stall_cycles", 64'(gaps[i]), 64'(e.gaps));
                    chk("preset_cycles", 64'(pre[i]), 64'd4);
                end
            end
            pr_prev[i] = prst[i];
            dn_prev[i] = done[i];
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_start(input int i);
        start[i] = 1'b1;
        @(negedge clk);
        start[i] = 1'b0;
    endtask

    task automatic send(input int i, input logic [31:0] w);
        int t = 0;
        word[i]  = w;
        valid[i] = 1'b1;
        while (!ready[i] && t < 500) begin @(negedge clk); t++; end
        if (t >= 500) begin
            checks++; errors++;
            $display("FAIL send_timeout: word %0h never accepted", w);
        end
        @(negedge clk);
        valid[i] = 1'b0;
    endtask

    task automatic wait_ready(input int i);
        int t = 0;
        while (!ready[i] && t < 500) begin @(negedge clk); t++; end
        if (t >= 500) begin
            checks++; errors++;
            $display("FAIL ready_timeout: instance %0d", i);
        end
    endtask

    task automatic wait_done(input int i);
        int t = 0;
        while (!done[i] && t < 500) begin @(negedge clk); t++; end
        if (t >= 500) begin
            checks++; errors++;
            $display("FAIL done_timeout: instance %0d", i);
        end
    endtask

    function automatic logic [7:0] outs(input int i);
        return {ready[i], prst[i], cfg[i], pclk[i], head[i], busy[i], done[i], err[i]};
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        stuck = 1'b0;
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b1; start[i] = 1'b0; word[i] = 32'h0; valid[i] = 1'b0;
        end
        cyc(2);
        chk("reset_outputs_64", 64'(outs(0)), 64'd0);
        chk("reset_outputs_40", 64'(outs(1)), 64'd0);
        rst[0] = 1'b0; rst[1] = 1'b0;
        cyc(1);

        // 1: back-to-back words, always valid
        push_exp(0, 1'b0, 64'hA5A50F0F12345678, 64, 0);
        do_start(0);
        send(0, 32'hA5A50F0F);
        send(0, 32'h12345678);
        wait_done(0);
        chk("done_state", 64'({done[0], busy[0], cfg[0], head[0]}), 64'h8);

        // 2: five-cycle source stall between the two words
        push_exp(0, 1'b0, 64'hA5A50F0F12345678, 64, 5);
        do_start(0);
        send(0, 32'hA5A50F0F);
        wait_ready(0);
        cyc(6);
        send(0, 32'h12345678);
        wait_done(0);

        // 3: 40-bit chain, tail of word 2 dropped
        push_exp(1, 1'b0, 64'h000000FFFF0000AB, 40, 0);
        do_start(1);
        send(1, 32'hFFFF0000);
        send(1, 32'hAB000000);
        wait_done(1);
        chk("ready_after_done_40", 64'(ready[1]), 64'd0);

        // 4: tail stuck at 0 with first bit 1
        stuck = 1'b1;
        push_exp(0, 1'b1, 64'h8000000000000000, 64, 0);
        do_start(0);
        send(0, 32'h80000000);
        send(0, 32'h00000000);
        wait_done(0);
        stuck = 1'b0;

        // 6: start in DONE restarts; start mid-SHIFT is ignored
        push_exp(0, 1'b0, 64'h0123456789ABCDEF, 64, 0);
        do_start(0);
        chk("restart_from_done", 64'({done[0], err[0], prst[0], busy[0]}), 64'h3);
        send(0, 32'h01234567);
        do_start(0);
        send(0, 32'h89ABCDEF);
        wait_done(0);

        // 5: reset mid-load abandons it, then a full load follows
        do_start(0);
        send(0, 32'hDEADBEEF);
        begin
            int t = 0;
            while (pulses[0] < 20 && t < 200) begin @(negedge clk); t++; end
            if (t >= 200) begin
                checks++; errors++;
                $display("FAIL pulse20_timeout: only %0d pulses", pulses[0]);
            end
        end
        rst[0] = 1'b1;
        #1;
        chk("async_reset_outputs", 64'(outs(0)), 64'd0);
        @(negedge clk);
        rst[0] = 1'b0;
        cyc(1);
        push_exp(0, 1'b0, 64'hCAFEF00D5A5AC3C3, 64, 0);
        do_start(0);
        send(0, 32'hCAFEF00D);
        send(0, 32'h5A5AC3C3);
        wait_done(0);

        cyc(3);
        chk("scoreboard_drained", 64'(q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
